// File: rtl/bpred_table.sv
// Direct-mapped branch predictor table: per-entry saturating counters, tags and targets.
// Combinational lookup for decode, registered update from execute, and a table-clear walk.
module bpred_table #(
    parameter int INDEX_BITS = 6,
    parameter int TAG_BITS   = 8,
    parameter int CTR_BITS   = 2,
    parameter int MISP_W     = 32
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic [31:0]       lookup_pc,
    output logic              pred_hit,
    output logic              pred_taken,
    output logic [31:0]       pred_target,
    input  logic              upd_valid,
    input  logic [31:0]       upd_pc,
    input  logic              upd_taken,
    input  logic [31:0]       upd_target,
    input  logic              upd_mispred,
    input  logic              clear,
    output logic              busy,
    output logic [MISP_W-1:0] mispred_cnt
);

    localparam int DEPTH = 1 << INDEX_BITS;
    localparam logic [CTR_BITS-1:0]   CTR_INIT = CTR_BITS'((1 << (CTR_BITS - 1)) - 1);
    localparam logic [CTR_BITS-1:0]   CTR_MAX  = '1;
    localparam logic [INDEX_BITS-1:0] LAST_IDX = '1;

    typedef enum logic {ST_IDLE, ST_CLEAR} state_t;

    state_t                  state_q, state_d;
    logic [INDEX_BITS-1:0]   ci_q, ci_d;
    logic                    clr_we, upd_we;

    logic                    valid_mem  [DEPTH];
    logic [TAG_BITS-1:0]     tag_mem    [DEPTH];
    logic [CTR_BITS-1:0]     ctr_mem    [DEPTH];
    logic [31:0]             target_mem [DEPTH];

    logic [INDEX_BITS-1:0]   lk_idx, up_idx;
    logic [TAG_BITS-1:0]     lk_tag, up_tag;
    logic                    up_hit;
    logic [CTR_BITS-1:0]     up_ctr, ctr_inc, ctr_dec;
    logic                    unused_pc_bits;

    assign lk_idx = lookup_pc[INDEX_BITS+1:2];
    assign lk_tag = lookup_pc[INDEX_BITS+TAG_BITS+1:INDEX_BITS+2];
    assign up_idx = upd_pc[INDEX_BITS+1:2];
    assign up_tag = upd_pc[INDEX_BITS+TAG_BITS+1:INDEX_BITS+2];

    assign unused_pc_bits = ^{lookup_pc[1:0], lookup_pc[31:INDEX_BITS+TAG_BITS+2],
                              upd_pc[1:0], upd_pc[31:INDEX_BITS+TAG_BITS+2]};

    // Lookup reads the pre-update contents; there is deliberately no bypass.
    assign pred_hit    = (state_q == ST_IDLE) && valid_mem[lk_idx] && (tag_mem[lk_idx] == lk_tag);
    assign pred_taken  = pred_hit && ctr_mem[lk_idx][CTR_BITS-1];
    assign pred_target = pred_taken ? target_mem[lk_idx] : lookup_pc + 32'd4;
    assign busy        = (state_q == ST_CLEAR);

    assign up_hit  = valid_mem[up_idx] && (tag_mem[up_idx] == up_tag);
    assign up_ctr  = ctr_mem[up_idx];
    assign ctr_inc = (up_ctr == CTR_MAX) ? up_ctr : up_ctr + CTR_BITS'(1);
    assign ctr_dec = (up_ctr == '0)      ? up_ctr : up_ctr - CTR_BITS'(1);

    always_ff @(posedge clk or negedge rstn) begin
        // NOTE: non-blocking assignments for all registered state, so every flop samples pre-edge values.
        if (!rstn) begin
            state_q <= ST_CLEAR;
            ci_q    <= '0;
        end else begin
            state_q <= state_d;
            ci_q    <= ci_d;
        end
    end

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can infer a latch.
        state_d = state_q;
        ci_d    = ci_q;
        clr_we  = 1'b0;
        upd_we  = 1'b0;
        case (state_q)
            ST_CLEAR: begin
                clr_we = 1'b1;
                ci_d   = ci_q + INDEX_BITS'(1);
                if (ci_q == LAST_IDX) state_d = ST_IDLE;
            end
            ST_IDLE: begin
                if (clear) begin
                    state_d = ST_CLEAR;
                    ci_d    = '0;
                end else begin
                    upd_we = upd_valid;
                end
            end
            default: state_d = ST_CLEAR;
        endcase
    end

    // NOTE: the table arrays carry no reset; the clear walk initialises them after rstn.
    always_ff @(posedge clk) begin
        if (clr_we) begin
            valid_mem[ci_q] <= 1'b0;
            ctr_mem[ci_q]   <= CTR_INIT;
        end else if (upd_we) begin
            if (up_hit) begin
                if (upd_taken) begin
                    ctr_mem[up_idx]    <= ctr_inc;
                    target_mem[up_idx] <= upd_target;
                end else begin
                    ctr_mem[up_idx] <= ctr_dec;
                end
            end else if (upd_taken) begin
                valid_mem[up_idx]  <= 1'b1;
                tag_mem[up_idx]    <= up_tag;
                target_mem[up_idx] <= upd_target;
                ctr_mem[up_idx]    <= CTR_INIT + CTR_BITS'(1);
            end
        end
    end

    // Statistic counts in every state and survives a table clear.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            mispred_cnt <= '0;
        end else if (upd_valid && upd_mispred && (mispred_cnt != '1)) begin
            mispred_cnt <= mispred_cnt + MISP_W'(1);
        end
    end

endmodule

// File: doc/bpred_table.md
Name: bpred_table

Overview:
- Parametrised branch predictor for the decode stage: a direct-mapped table of per-entry saturating counters, tags and branch targets, indexed by PC.
- Supersedes the single global 2-bit counter in decode with per-branch prediction, target supply and a mispredict statistic.
- Decode looks up combinationally to form npc. Execute/writeback returns the resolved outcome through the update port one or more cycles later.

Parameters:
- INDEX_BITS, 6: table has 2^INDEX_BITS entries; index = pc[INDEX_BITS+1:2].
- TAG_BITS, 8: tag = pc[INDEX_BITS+TAG_BITS+1:INDEX_BITS+2].
- CTR_BITS, 2: counter width (>=1). Predict taken when counter MSB = 1.
- MISP_W, 32: width of the mispredict statistic counter.

Ports:
- clk  in  1  clock.
- rstn  in  1  asynchronous active-low reset.
- lookup_pc  in  32  PC of the instruction in decode.
- pred_hit  out  1  entry valid, tag matches and block is IDLE.
- pred_taken  out  1  pred_hit && counter MSB.
- pred_target  out  32  stored target if pred_taken, else lookup_pc+4.
- upd_valid  in  1  resolved branch this cycle.
- upd_pc  in  32  PC of the resolved branch.
- upd_taken  in  1  actual outcome.
- upd_target  in  32  actual branch target.
- upd_mispred  in  1  prediction was wrong (statistic only).
- clear  in  1  single-cycle pulse: invalidate the whole table.
- busy  out  1  high while the table is being cleared.
- mispred_cnt  out  MISP_W  count of mispredicts.

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-low on rstn.
- Storage: arrays valid, tag, ctr and target, one element per entry, held in distributed RAM. The arrays are not reset directly; they are initialised by the CLEAR walk.
- CTR_INIT = 2^(CTR_BITS-1)-1 (weakly not-taken). CTR_MAX = 2^CTR_BITS-1.
- FSM states: IDLE, CLEAR. Internal clear index ci is INDEX_BITS wide.
- rstn low (asynchronous): state=CLEAR, ci=0, mispred_cnt=0, busy=1.
  - While in reset, pred_hit=0, pred_taken=0, pred_target=lookup_pc+4.
- CLEAR state:
  - Each cycle write entry ci: valid=0, ctr=CTR_INIT, ci++.
  - After writing entry 2^INDEX_BITS-1, go to IDLE next cycle. CLEAR lasts exactly 2^INDEX_BITS cycles.
  - busy=1 throughout CLEAR, 0 in IDLE.
  - Updates arriving during CLEAR are dropped.
  - A clear pulse during CLEAR is ignored; the walk does not restart.
- IDLE + clear: go to CLEAR with ci=0 next cycle. If upd_valid is high in the same cycle, clear wins and that update is dropped.
- Lookup (combinational, zero latency):
  - hit = (state==IDLE) && valid[idx] && tag[idx]==tag(lookup_pc).
  - No same-cycle bypass from the update port. A write becomes visible to lookup on the cycle after the update.
- Update (IDLE, upd_valid=1, registered at clk edge):
  - Hit, taken: ctr = min(ctr+1, CTR_MAX); target = upd_target.
  - Hit, not taken: ctr = max(ctr-1, 0); target unchanged.
  - Miss, taken: allocate the entry, overwriting any alias. valid=1, tag=tag(upd_pc), target=upd_target, ctr=CTR_INIT+1.
  - Miss, not taken: no change.
- mispred_cnt:
  - +1 on every cycle with upd_valid && upd_mispred, regardless of FSM state.
  - Saturates at all-ones.
  - Cleared only by rstn, not by clear.
- Lookup and update to the same index in the same cycle: lookup sees the old contents.
- Reset asserted mid-CLEAR or mid-update: the walk restarts at index 0, and the in-flight update is lost.

Test Plan:
- Reset, then hold: busy=1 for exactly 64 cycles, then 0. Lookup 0x100 gives hit=0, taken=0, target=0x104.
- Update pc=0x100, taken, target=0x200, then lookup 0x100 next cycle: hit=1, taken=1 (ctr=2), target=0x200. Lookup in the same cycle as the update: hit=0.
- After the allocation above, update 0x100 not-taken twice: ctr 1 then 0, taken=0, hit=1, target=0x104. Five taken updates: ctr saturates at 3. One not-taken: ctr=2, still taken.
- Alias: allocate 0x100, then lookup 0x200 (same index, different tag): hit=0. Taken update at 0x200 with target 0x300: 0x200 hits, 0x100 misses. A not-taken update at a missing PC leaves the table unchanged.
- clear pulse in IDLE: busy=1 for 64 cycles. Updates and a second clear issued during the walk are ignored. Afterwards all lookups miss. mispred_cnt keeps its value.
- MISP_W=4: 20 cycles of upd_valid && upd_mispred (some issued during CLEAR) give mispred_cnt=15. Asserting rstn low mid-walk gives busy=1, mispred_cnt=0, and a full 64-cycle walk restarts.
